// File: rtl/qpu_exu_longpwbck_mc.sv
// qpu_exu_longpwbck_mc
//   Long-pipe write-back arbiter. Several long-latency units (channels) each
//   present a result tagged with the OITF itag it belongs to. Only the channel
//   whose itag equals the oldest OITF entry may retire, so results leave in
//   program order. A retiring entry that writes a register is staged in a
//   one-deep output register towards the final write-back stage; an entry
//   with no destination retires without touching that register.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   ch_valid/ch_ready   : per-channel handshake (NCH bits)
//   ch_data             : per-channel result, channel i at [i*DW +: DW]
//   ch_itag             : per-channel OITF itag, channel i at [i*TW +: TW]
//   oitf_empty          : OITF holds no entry
//   oitf_ret_ptr        : itag of the oldest OITF entry
//   oitf_ret_rdidx      : destination register of the oldest entry
//   oitf_ret_rdwen      : oldest entry writes a register
//   oitf_ret_ena        : retire the oldest entry this cycle
//   longp_wbck_o_*      : registered write-back towards final wbck
//   collide_err         : sticky, two channels claimed the same retire slot
//   stall_cnt           : saturating count of output-blocked cycles

`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif
`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif

module qpu_exu_longpwbck_mc #(
  parameter int NCH = 2,
  parameter int DW  = `QPU_XLEN,
  parameter int RW  = `QPU_RFIDX_REAL_WIDTH,
  parameter int TW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_valid,
  output logic [NCH-1:0]    ch_ready,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH*TW-1:0] ch_itag,
  input  logic              oitf_empty,
  input  logic [TW-1:0]     oitf_ret_ptr,
  input  logic [RW-1:0]     oitf_ret_rdidx,
  input  logic              oitf_ret_rdwen,
  output logic              oitf_ret_ena,
  output logic              longp_wbck_o_valid,
  input  logic              longp_wbck_o_ready,
  output logic [DW-1:0]     longp_wbck_o_data,
  output logic [RW-1:0]     longp_wbck_o_rdidx,
  output logic              collide_err,
  output logic [15:0]       stall_cnt
);

  logic [NCH-1:0] w_match;
  logic           w_sel_vld;
  logic [DW-1:0]  w_sel_data;
  logic [NCH-1:0] w_sel_onehot;
  logic [3:0]     w_match_cnt;
  logic           w_multi;
  logic           w_out_free;
  logic           w_can_take;
  logic           w_accept;
  logic           w_stall;

  logic           r_valid;
  logic [DW-1:0]  r_data;
  logic [RW-1:0]  r_rdidx;
  logic           r_collide;
  logic [15:0]    r_stall_cnt;

  // Only the channel holding the oldest itag may retire.
  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_match[i] = ch_valid[i] & (ch_itag[i*TW +: TW] == oitf_ret_ptr) & ~oitf_empty;
    end
  end

  // Scan from the top down so the lowest-index match is the last one written.
  always_comb begin
    w_sel_onehot = '0;
    w_sel_data   = '0;
    w_match_cnt  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (w_match[NCH-1-k]) begin
        w_sel_onehot = '0;
        w_sel_onehot[NCH-1-k] = 1'b1;
        w_sel_data   = ch_data[(NCH-1-k)*DW +: DW];
        w_match_cnt  = w_match_cnt + 4'd1;
      end
    end
  end

  assign w_sel_vld  = |w_match;
  assign w_multi    = (w_match_cnt > 4'd1);
  assign w_out_free = ~r_valid | longp_wbck_o_ready;
  // Entries without a destination never wait for the output register.
  assign w_can_take = (oitf_ret_rdwen ? w_out_free : 1'b1) & ~rst;
  assign w_accept   = w_sel_vld & w_can_take;
  assign w_stall    = w_sel_vld & oitf_ret_rdwen & ~w_out_free;

  assign ch_ready     = w_can_take ? w_sel_onehot : '0;
  assign oitf_ret_ena = w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_rdidx     <= '0;
      r_collide   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // A load in the same cycle as a drain keeps valid high: one word/cycle.
      if (w_accept & oitf_ret_rdwen) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_rdidx <= oitf_ret_rdidx;
      end else if (r_valid & longp_wbck_o_ready) begin
        r_valid <= 1'b0;
      end
      if (w_multi) begin
        r_collide <= 1'b1;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign longp_wbck_o_valid = r_valid;
  assign longp_wbck_o_data  = r_data;
  assign longp_wbck_o_rdidx = r_rdidx;
  assign collide_err        = r_collide;
  assign stall_cnt          = r_stall_cnt;

endmodule

// File: tb/tb_qpu_exu_longpwbck_mc.sv
module tb_qpu_exu_longpwbck_mc;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int TW  = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
  } wb_t;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH*TW-1:0] ch_itag;
  logic              oitf_empty;
  logic [TW-1:0]     oitf_ret_ptr;
  logic [RW-1:0]     oitf_ret_rdidx;
  logic              oitf_ret_rdwen;
  logic              oitf_ret_ena;
  logic              longp_wbck_o_valid;
  logic              longp_wbck_o_ready;
  logic [DW-1:0]     longp_wbck_o_data;
  logic [RW-1:0]     longp_wbck_o_rdidx;
  logic              collide_err;
  logic [15:0]       stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  wb_t exp_q[$];

  qpu_exu_longpwbck_mc #(
    .NCH(NCH),
    .DW (DW),
    .RW (RW),
    .TW (TW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ch_valid          (ch_valid),
    .ch_ready          (ch_ready),
    .ch_data           (ch_data),
    .ch_itag           (ch_itag),
    .oitf_empty        (oitf_empty),
    .oitf_ret_ptr      (oitf_ret_ptr),
    .oitf_ret_rdidx    (oitf_ret_rdidx),
    .oitf_ret_rdwen    (oitf_ret_rdwen),
    .oitf_ret_ena      (oitf_ret_ena),
    .longp_wbck_o_valid(longp_wbck_o_valid),
    .longp_wbck_o_ready(longp_wbck_o_ready),
    .longp_wbck_o_data (longp_wbck_o_data),
    .longp_wbck_o_rdidx(longp_wbck_o_rdidx),
    .collide_err       (collide_err),
    .stall_cnt         (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every output handshake pops the oldest expected word.
  always @(negedge clk) begin
    if (!rst && longp_wbck_o_valid && longp_wbck_o_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got data=%h rdidx=%0d, expected no write-back",
                 longp_wbck_o_data, longp_wbck_o_rdidx);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (longp_wbck_o_data !== e.d || longp_wbck_o_rdidx !== e.r) begin
          n_err++;
          $display("FAIL wb_word: got data=%h rdidx=%0d, expected data=%h rdidx=%0d",
                   longp_wbck_o_data, longp_wbck_o_rdidx, e.d, e.r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [TW-1:0] tag, input logic [DW-1:0] d);
    ch_valid[ch]            = 1'b1;
    ch_itag[ch*TW +: TW]    = tag;
    ch_data[ch*DW +: DW]    = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_valid = '0;
    longp_wbck_o_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    oitf_empty = 1'b0;
    oitf_ret_ptr = 2'd1;
    oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b1;
    set_ch(0, 2'd1, 32'h1);
    set_ch(1, 2'd1, 32'h2);
    @(negedge clk);
    n_cmp++;
    if (ch_ready !== 2'b00 || oitf_ret_ena !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: ch_ready=%b ret_ena=%b, expected 00/0", ch_ready, oitf_ret_ena);
    end
    step();
    step();
    n_cmp++;
    if (longp_wbck_o_valid !== 1'b0 || longp_wbck_o_data !== '0 || longp_wbck_o_rdidx !== '0 ||
        collide_err !== 1'b0 || stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: v=%b d=%h r=%0d col=%b stall=%0d, expected all zero",
               longp_wbck_o_valid, longp_wbck_o_data, longp_wbck_o_rdidx, collide_err, stall_cnt);
    end
    ch_valid = '0;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_basic();
    oitf_ret_ptr = 2'd1;
    oitf_ret_rdidx = 5'd7;
    oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b1;
    set_ch(1, 2'd1, 32'hA5A5);
    @(negedge clk);
    n_cmp++;
    if (ch_ready !== 2'b10 || oitf_ret_ena !== 1'b1) begin
      n_err++;
      $display("FAIL basic_accept: ch_ready=%b ret_ena=%b, expected 10/1", ch_ready, oitf_ret_ena);
    end
    exp_q.push_back('{d: 32'hA5A5, r: 5'd7});
    step();
    ch_valid = '0;
    n_cmp++;
    if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_data !== 32'hA5A5 || longp_wbck_o_rdidx !== 5'd7) begin
      n_err++;
      $display("FAIL basic_latency: v=%b d=%h r=%0d, expected 1/0000a5a5/7",
               longp_wbck_o_valid, longp_wbck_o_data, longp_wbck_o_rdidx);
    end
    step();
  endtask

  task automatic test_inorder();
    oitf_ret_ptr = 2'd1;
    oitf_ret_rdidx = 5'd3;
    longp_wbck_o_ready = 1'b1;
    set_ch(0, 2'd2, 32'h1234);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ch_ready !== 2'b00 || oitf_ret_ena !== 1'b0) begin
        n_err++;
        $display("FAIL inorder_hold: ch_ready=%b ret_ena=%b, expected 00/0", ch_ready, oitf_ret_ena);
      end
      step();
    end
    // Matching itag, but the OITF reports empty.
    oitf_ret_ptr = 2'd2;
    oitf_empty = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ch_ready !== 2'b00 || oitf_ret_ena !== 1'b0) begin
      n_err++;
      $display("FAIL empty_block: ch_ready=%b ret_ena=%b, expected 00/0", ch_ready, oitf_ret_ena);
    end
    step();
    oitf_empty = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ch_ready !== 2'b01 || oitf_ret_ena !== 1'b1) begin
      n_err++;
      $display("FAIL inorder_release: ch_ready=%b ret_ena=%b, expected 01/1", ch_ready, oitf_ret_ena);
    end
    exp_q.push_back('{d: 32'h1234, r: 5'd3});
    step();
    ch_valid = '0;
    step();
  endtask

  task automatic test_stall();
    do_reset();
    oitf_ret_ptr = 2'd0;
    oitf_ret_rdidx = 5'd1;
    oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b0;
    set_ch(0, 2'd0, 32'h1111);
    @(negedge clk);
    n_cmp++;
    if (oitf_ret_ena !== 1'b1) begin
      n_err++;
      $display("FAIL stall_first_load: ret_ena=%b, expected 1", oitf_ret_ena);
    end
    exp_q.push_back('{d: 32'h1111, r: 5'd1});
    step();
    set_ch(0, 2'd0, 32'h2222);
    oitf_ret_rdidx = 5'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (oitf_ret_ena !== 1'b0 || ch_ready !== 2'b00 || longp_wbck_o_data !== 32'h1111 ||
          longp_wbck_o_rdidx !== 5'd1) begin
        n_err++;
        $display("FAIL stall_hold: ret_ena=%b ch_ready=%b d=%h r=%0d, expected 0/00/00001111/1",
                 oitf_ret_ena, ch_ready, longp_wbck_o_data, longp_wbck_o_rdidx);
      end
      step();
    end
    n_cmp++;
    if (stall_cnt !== 16'd5) begin
      n_err++;
      $display("FAIL stall_count: got %0d, expected 5", stall_cnt);
    end
    longp_wbck_o_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (oitf_ret_ena !== 1'b1 || ch_ready !== 2'b01) begin
      n_err++;
      $display("FAIL stall_reload: ret_ena=%b ch_ready=%b, expected 1/01", oitf_ret_ena, ch_ready);
    end
    exp_q.push_back('{d: 32'h2222, r: 5'd2});
    step();
    ch_valid = '0;
    n_cmp++;
    if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_data !== 32'h2222) begin
      n_err++;
      $display("FAIL stall_sustain: v=%b d=%h, expected 1/00002222", longp_wbck_o_valid, longp_wbck_o_data);
    end
    step();
    n_cmp++;
    if (longp_wbck_o_valid !== 1'b0 || stall_cnt !== 16'd5) begin
      n_err++;
      $display("FAIL stall_drain: v=%b stall=%0d, expected 0/5", longp_wbck_o_valid, stall_cnt);
    end
  endtask

  task automatic test_nowb();
    oitf_ret_ptr = 2'd3;
    oitf_ret_rdidx = 5'd4;
    oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b0;
    set_ch(0, 2'd3, 32'h3333);
    exp_q.push_back('{d: 32'h3333, r: 5'd4});
    step();
    ch_valid = '0;
    oitf_ret_ptr = 2'd0;
    oitf_ret_rdidx = 5'd9;
    oitf_ret_rdwen = 1'b0;
    set_ch(1, 2'd0, 32'hDEAD);
    @(negedge clk);
    n_cmp++;
    if (oitf_ret_ena !== 1'b1 || ch_ready !== 2'b10) begin
      n_err++;
      $display("FAIL nowb_accept: ret_ena=%b ch_ready=%b, expected 1/10", oitf_ret_ena, ch_ready);
    end
    step();
    ch_valid = '0;
    n_cmp++;
    if (longp_wbck_o_valid !== 1'b1 || longp_wbck_o_data !== 32'h3333 || longp_wbck_o_rdidx !== 5'd4 ||
        stall_cnt !== 16'd5) begin
      n_err++;
      $display("FAIL nowb_untouched: v=%b d=%h r=%0d stall=%0d, expected 1/00003333/4/5",
               longp_wbck_o_valid, longp_wbck_o_data, longp_wbck_o_rdidx, stall_cnt);
    end
    longp_wbck_o_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [TW-1:0] tag;
      tag = TW'(k);
      oitf_ret_ptr = tag;
      oitf_ret_rdidx = RW'(10 + k);
      ch_valid = '0;
      set_ch(k % 2, tag, 32'hB000 + k);
      @(negedge clk);
      n_cmp++;
      if (oitf_ret_ena !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_accept: beat %0d ret_ena=%b, expected 1", k, oitf_ret_ena);
      end
      exp_q.push_back('{d: 32'hB000 + k, r: RW'(10 + k)});
      step();
    end
    ch_valid = '0;
    step();
  endtask

  task automatic test_collide();
    do_reset();
    n_cmp++;
    if (collide_err !== 1'b0) begin
      n_err++;
      $display("FAIL collide_init: got %b, expected 0", collide_err);
    end
    oitf_ret_ptr = 2'd2;
    oitf_ret_rdidx = 5'd9;
    oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b1;
    set_ch(0, 2'd2, 32'hAAAA);
    set_ch(1, 2'd2, 32'hBBBB);
    @(negedge clk);
    n_cmp++;
    if (ch_ready !== 2'b01 || oitf_ret_ena !== 1'b1) begin
      n_err++;
      $display("FAIL collide_winner: ch_ready=%b ret_ena=%b, expected 01/1", ch_ready, oitf_ret_ena);
    end
    exp_q.push_back('{d: 32'hAAAA, r: 5'd9});
    step();
    ch_valid = '0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (collide_err !== 1'b1) begin
        n_err++;
        $display("FAIL collide_sticky: cycle %0d got %b, expected 1", k, collide_err);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    oitf_ret_ptr = 2'd1;
    oitf_ret_rdidx = 5'd6;
    oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b0;
    set_ch(0, 2'd1, 32'h5555);
    step();
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ch_ready !== 2'b00 || oitf_ret_ena !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_ready: ch_ready=%b ret_ena=%b, expected 00/0", ch_ready, oitf_ret_ena);
    end
    step();
    rst = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (longp_wbck_o_valid !== 1'b0 || stall_cnt !== 16'd0 || collide_err !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_state: v=%b stall=%0d col=%b, expected 0/0/0",
               longp_wbck_o_valid, stall_cnt, collide_err);
    end
    longp_wbck_o_ready = 1'b1;
    set_ch(0, 2'd1, 32'h6666);
    @(negedge clk);
    n_cmp++;
    if (oitf_ret_ena !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_first: ret_ena=%b, expected 1", oitf_ret_ena);
    end
    exp_q.push_back('{d: 32'h6666, r: 5'd6});
    step();
    ch_valid = '0;
    step();
  endtask

  task automatic test_saturate();
    oitf_ret_ptr = 2'd0;
    oitf_ret_rdidx = 5'd8;
    oitf_ret_rdwen = 1'b1;
    longp_wbck_o_ready = 1'b0;
    set_ch(1, 2'd0, 32'h7777);
    exp_q.push_back('{d: 32'h7777, r: 5'd8});
    step();
    set_ch(1, 2'd0, 32'h8888);
    force dut.r_stall_cnt = 16'hFFFC;
    step();
    release dut.r_stall_cnt;
    for (int k = 0; k < 5; k++) step();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_reach: got %h, expected ffff", stall_cnt);
    end
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hold: got %h, expected ffff", stall_cnt);
    end
    ch_valid = '0;
    longp_wbck_o_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    ch_valid = '0;
    ch_data = '0;
    ch_itag = '0;
    oitf_empty = 1'b0;
    oitf_ret_ptr = '0;
    oitf_ret_rdidx = '0;
    oitf_ret_rdwen = 1'b0;
    longp_wbck_o_ready = 1'b0;

    test_reset();
    test_basic();
    test_inorder();
    test_stall();
    test_nowb();
    test_back_to_back();
    test_collide();
    test_reset_mid();
    test_saturate();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wb_missing: %0d expected words never written back, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qpu_exu_longpwbck_mc.md
QPU_EXU_LONGPWBCK_MC -- requirements
Module: QPU_exu_longpwbck_mc

Interface
REQ-001 SHALL have parameter NCH, default 2: number of long-pipe write-back source channels (1..8).
REQ-002 SHALL have parameter DW, default `QPU_XLEN: write-back data width.
REQ-003 SHALL have parameter RW, default `QPU_RFIDX_REAL_WIDTH: register index width.
REQ-004 SHALL have parameter TW, default 2: OITF itag width (OITF depth 2^TW).
REQ-005 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ch_valid  in  NCH  per-channel write-back valid
- ch_ready  out  NCH  per-channel write-back ready
- ch_data  in  NCH*DW  per-channel data, channel i at [i*DW +: DW]
- ch_itag  in  NCH*TW  per-channel OITF itag, channel i at [i*TW +: TW]
- oitf_empty  in  1  OITF holds no entry
- oitf_ret_ptr  in  TW  itag of oldest OITF entry
- oitf_ret_rdidx  in  RW  destination index of oldest entry
- oitf_ret_rdwen  in  1  oldest entry writes a register
- oitf_ret_ena  out  1  retire oldest OITF entry this cycle
- longp_wbck_o_valid  out  1  registered write-back valid to final wbck
- longp_wbck_o_ready  in  1  final wbck ready
- longp_wbck_o_data  out  DW  write-back data
- longp_wbck_o_rdidx  out  RW  write-back register index
- collide_err  out  1  sticky: two channels claimed the same retire slot
- stall_cnt  out  16  saturating count of output-blocked cycles

Function
REQ-006 SHALL compute match[i] = ch_valid[i] & (ch_itag[i] == oitf_ret_ptr) & ~oitf_empty; non-matching valid channels SHALL be held (ch_ready[i]=0), enforcing in-order retirement.
REQ-007 SHALL select the lowest-index matching channel (sel); sel_vld = |match.
REQ-008 SHALL define out_free = ~longp_wbck_o_valid | longp_wbck_o_ready.
REQ-009 SHALL define accept = sel_vld & (oitf_ret_rdwen ? out_free : 1); oitf_ret_ena = accept; ch_ready[sel] = accept-condition without sel_vld term; all other ch_ready bits 0.
REQ-010 SHALL, on accept with oitf_ret_rdwen=1, load output register next edge: valid=1, data=ch_data[sel], rdidx=oitf_ret_rdidx; latency accept -> longp_wbck_o_valid exactly 1 cycle.
REQ-011 SHALL, on accept with oitf_ret_rdwen=0, retire without touching output register (no write-back, no dependence on longp_wbck_o_ready).
REQ-012 SHALL clear output valid on handshake (valid & ready) when no new load occurs same cycle; simultaneous drain and load SHALL sustain 1 write-back/cycle.
REQ-013 SHALL hold longp_wbck_o_data/rdidx stable while valid & ~ready.
REQ-014 SHALL set collide_err when popcount(match) > 1 in any cycle; sticky until reset; the lowest-index channel still wins.
REQ-015 SHALL increment stall_cnt each cycle with sel_vld & oitf_ret_rdwen & ~out_free; saturate at 16'hFFFF (no wrap).
REQ-016 SHALL produce no accept when oitf_empty=1 regardless of ch_valid.
REQ-017 SHALL be a purely synchronous design; ch_ready and oitf_ret_ena combinational from inputs and output-register state only.

Reset
REQ-018 SHALL, while rst=1, force ch_ready=0 and oitf_ret_ena=0.
REQ-019 SHALL reset on rising edge with rst=1: longp_wbck_o_valid=0, longp_wbck_o_data=0, longp_wbck_o_rdidx=0, collide_err=0, stall_cnt=0.
REQ-020 SHALL discard a pending un-handshaken output word when reset asserts mid-operation; first accept possible cycle after rst deasserts.

Verification
REQ-021 NCH=2, ret_ptr=1, ch1 itag=1 data=0xA5A5, rdwen=1, rdidx=7, ready=1 -> ch_ready=2'b10, ret_ena=1 same cycle; next cycle o_valid=1, data=0xA5A5, rdidx=7.
REQ-022 ch0 valid itag=2, ret_ptr=1 -> ch_ready=0, ret_ena=0 indefinitely; change ret_ptr=2 -> ch0 accepted that cycle.
REQ-023 output valid, ready=0 for 5 cycles, ch0 matching rdwen=1 -> no accept, stall_cnt=5, data held; ready=1 -> drain and new load same cycle, o_valid stays 1.
REQ-024 matching channel with rdwen=0, ready=0, output full -> ret_ena=1, output register unchanged.
REQ-025 ch0 and ch1 both itag=ret_ptr -> ch_ready=2'b01, collide_err=1 next cycle and remains 1 until rst.
REQ-026 rst pulsed while o_valid=1 -> next cycle o_valid=0, stall_cnt=0, collide_err=0; stall_cnt forced to 16'hFFFF scenario holds at 16'hFFFF.
